// File: rtl/conv2d_3x3.sv
// rtl/conv2d_3x3.sv - 3x3 valid convolution over a buffered HWC image, sequential MAC
// Kernel and image are held on-chip; one multiply per cycle, results saturated per filter lane.
module conv2d_3x3 #(
   parameter  int IN_HEIGHT        = 4,
   parameter  int IN_WIDTH         = 4,
   parameter  int IN_CHANNEL       = 2,
   parameter  int WORDS            = 1,
   parameter  int WORD_WIDTH       = 8,
   parameter  int FILTERS          = 8,
   parameter  int KERNEL_BUF_WIDTH = 32,
   localparam int WIDTH            = WORD_WIDTH * WORDS,
   localparam int FPL              = KERNEL_BUF_WIDTH / WIDTH
) (
   input  logic                          i_aclk,
   input  logic                          i_aresetn,
   input  logic                          i_tvalid,
   output logic                          o_tready,
   input  logic [WIDTH-1:0]              i_tdata,
   input  logic                          i_kernel_tvalid,
   output logic                          o_kernel_tready,
   input  logic [KERNEL_BUF_WIDTH-1:0]   i_kernel_tdata,
   input  logic                          i_tready,
   output logic                          o_tvalid,
   output logic [FPL*WORD_WIDTH-1:0]     o_tdata
);

   localparam int KDEPTH    = 9 * FILTERS * IN_CHANNEL * WORD_WIDTH / KERNEL_BUF_WIDTH;
   localparam int IMG_WORDS = IN_HEIGHT * IN_WIDTH * IN_CHANNEL;
   localparam int KER_WORDS = 9 * IN_CHANNEL * FILTERS;
   localparam int IMG_AW    = $clog2(IMG_WORDS);
   localparam int KER_AW    = $clog2(KER_WORDS);
   localparam int BEATS     = FILTERS / FPL;
   localparam int PROD_W    = 2 * WORD_WIDTH;
   localparam int ACC_W     = PROD_W + $clog2(9 * IN_CHANNEL) + 1;
   localparam int CW        = 16;

   localparam logic [CW-1:0] LAST_PIX   = CW'(IMG_WORDS - 1);
   localparam logic [CW-1:0] LAST_KBEAT = CW'(KDEPTH - 1);
   localparam logic [CW-1:0] LAST_OY    = CW'(IN_HEIGHT - 3);
   localparam logic [CW-1:0] LAST_OX    = CW'(IN_WIDTH - 3);
   localparam logic [CW-1:0] LAST_BEAT  = CW'(BEATS - 1);
   localparam logic [CW-1:0] LAST_LANE  = CW'(FPL - 1);
   localparam logic [CW-1:0] LAST_C     = CW'(IN_CHANNEL - 1);
   localparam logic [CW-1:0] LAST_K     = CW'(2);

   localparam logic signed [ACC_W-1:0] SAT_MAX =
      {{(ACC_W-WORD_WIDTH+1){1'b0}}, {(WORD_WIDTH-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] SAT_MIN =
      {{(ACC_W-WORD_WIDTH+1){1'b1}}, {(WORD_WIDTH-1){1'b0}}};

   typedef enum logic [1:0] {ST_FILL, ST_WAIT, ST_MAC, ST_OUT} state_t;

   state_t r_state;
   state_t w_next;

   logic signed [WORD_WIDTH-1:0] r_img [IMG_WORDS];
   logic signed [WORD_WIDTH-1:0] r_ker [KER_WORDS];

   logic [CW-1:0]             r_pix;
   logic [CW-1:0]             r_kcnt;
   logic                      r_kloaded;
   logic [CW-1:0]             r_oy;
   logic [CW-1:0]             r_ox;
   logic [CW-1:0]             r_beat;
   logic [CW-1:0]             r_lane;
   logic [CW-1:0]             r_ky;
   logic [CW-1:0]             r_kx;
   logic [CW-1:0]             r_c;
   logic signed [ACC_W-1:0]   r_acc;
   logic [FPL*WORD_WIDTH-1:0] r_tdata;

   logic                      w_pix_hs;
   logic                      w_k_hs;
   logic                      w_out_hs;
   logic                      w_last_term;
   logic                      w_last_lane;
   logic                      w_last_beat;
   logic                      w_last_ox;
   logic                      w_last_oy;
   logic [IMG_AW-1:0]         w_img_idx;
   logic [KER_AW-1:0]         w_ker_idx;
   logic signed [PROD_W-1:0]  w_prod;
   logic signed [ACC_W-1:0]   w_sum;
   logic [WORD_WIDTH-1:0]     w_sat;

   assign w_pix_hs    = i_tvalid && (r_state == ST_FILL);
   assign w_k_hs      = i_kernel_tvalid && !r_kloaded;
   assign w_out_hs    = (r_state == ST_OUT) && i_tready;
   assign w_last_term = (r_ky == LAST_K) && (r_kx == LAST_K) && (r_c == LAST_C);
   assign w_last_lane = (r_lane == LAST_LANE);
   assign w_last_beat = (r_beat == LAST_BEAT);
   assign w_last_ox   = (r_ox == LAST_OX);
   assign w_last_oy   = (r_oy == LAST_OY);

   // HWC addressing for the image, (ky,kx,c,f) with filter fastest for the kernel
   assign w_img_idx = IMG_AW'(((32'(r_oy) + 32'(r_ky)) * 32'(IN_WIDTH) + 32'(r_ox) + 32'(r_kx))
                              * 32'(IN_CHANNEL) + 32'(r_c));
   assign w_ker_idx = KER_AW'(((32'(r_ky) * 32'd3 + 32'(r_kx)) * 32'(IN_CHANNEL) + 32'(r_c))
                              * 32'(FILTERS) + 32'(r_beat) * 32'(FPL) + 32'(r_lane));

   assign w_prod = PROD_W'(r_img[w_img_idx]) * PROD_W'(r_ker[w_ker_idx]);
   assign w_sum  = r_acc + ACC_W'(w_prod);

   always_comb begin
      w_sat = w_sum[WORD_WIDTH-1:0];
      if (w_sum > SAT_MAX) begin
         w_sat = {1'b0, {(WORD_WIDTH-1){1'b1}}};
      end else if (w_sum < SAT_MIN) begin
         w_sat = {1'b1, {(WORD_WIDTH-1){1'b0}}};
      end
   end

   always_ff @(posedge i_aclk or negedge i_aresetn) begin
      if (!i_aresetn) begin
         r_state <= ST_FILL;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next          = r_state;
      o_tready        = (r_state == ST_FILL);
      o_tvalid        = (r_state == ST_OUT);
      o_kernel_tready = !r_kloaded;
      o_tdata         = r_tdata;
      case (r_state)
         ST_FILL: if (w_pix_hs && (r_pix == LAST_PIX)) w_next = ST_WAIT;
         ST_WAIT: if (r_kloaded) w_next = ST_MAC;
         ST_MAC:  if (w_last_term && w_last_lane) w_next = ST_OUT;
         ST_OUT: begin
            if (i_tready) begin
               w_next = (w_last_beat && w_last_ox && w_last_oy) ? ST_FILL : ST_MAC;
            end
         end
         default: w_next = ST_FILL;
      endcase
   end

   // Buffers carry no reset: counters and flags decide what is valid
   always_ff @(posedge i_aclk) begin
      if (w_pix_hs) begin
         r_img[r_pix[IMG_AW-1:0]] <= i_tdata[WORD_WIDTH-1:0];
      end
      if (w_k_hs) begin
         for (int l = 0; l < FPL; l++) begin
            r_ker[KER_AW'(32'(r_kcnt) * 32'(FPL) + 32'(l))] <= i_kernel_tdata[l*WIDTH +: WORD_WIDTH];
         end
      end
   end

   always_ff @(posedge i_aclk or negedge i_aresetn) begin
      if (!i_aresetn) begin
         r_pix     <= '0;
         r_kcnt    <= '0;
         r_kloaded <= 1'b0;
      end else begin
         if (w_pix_hs) begin
            r_pix <= (r_pix == LAST_PIX) ? '0 : r_pix + CW'(1);
         end
         if (w_k_hs) begin
            if (r_kcnt == LAST_KBEAT) begin
               r_kcnt    <= '0;
               r_kloaded <= 1'b1;
            end else begin
               r_kcnt <= r_kcnt + CW'(1);
            end
         end
      end
   end

   always_ff @(posedge i_aclk or negedge i_aresetn) begin
      if (!i_aresetn) begin
         r_oy    <= '0;
         r_ox    <= '0;
         r_beat  <= '0;
         r_lane  <= '0;
         r_ky    <= '0;
         r_kx    <= '0;
         r_c     <= '0;
         r_acc   <= '0;
         r_tdata <= '0;
      end else if (r_state == ST_MAC) begin
         if (w_last_term) begin
            r_acc <= '0;
            r_ky  <= '0;
            r_kx  <= '0;
            r_c   <= '0;
            r_lane <= w_last_lane ? '0 : r_lane + CW'(1);
            for (int l = 0; l < FPL; l++) begin
               if (r_lane == CW'(l)) r_tdata[l*WORD_WIDTH +: WORD_WIDTH] <= w_sat;
            end
         end else begin
            r_acc <= w_sum;
            if (r_c == LAST_C) begin
               r_c <= '0;
               if (r_kx == LAST_K) begin
                  r_kx <= '0;
                  r_ky <= r_ky + CW'(1);
               end else begin
                  r_kx <= r_kx + CW'(1);
               end
            end else begin
               r_c <= r_c + CW'(1);
            end
         end
      end else if (w_out_hs) begin
         if (w_last_beat) begin
            r_beat <= '0;
            if (w_last_ox) begin
               r_ox <= '0;
               r_oy <= w_last_oy ? '0 : r_oy + CW'(1);
            end else begin
               r_ox <= r_ox + CW'(1);
            end
         end else begin
            r_beat <= r_beat + CW'(1);
         end
      end
   end

endmodule

// File: tb/tb_conv2d_3x3.sv
// tb/tb_conv2d_3x3.sv - scoreboard bench for conv2d_3x3 with directed kernels and images
module tb_conv2d_3x3;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        i_tvalid;
   logic        o_tready;
   logic [7:0]  i_tdata;
   logic        i_kernel_tvalid;
   logic        o_kernel_tready;
   logic [31:0] i_kernel_tdata;
   logic        i_tready;
   logic        o_tvalid;
   logic [31:0] o_tdata;

   logic [31:0] sb[$];
   logic [31:0] mon_exp;
   int          n_tests = 0;
   int          n_fail  = 0;
   int          n_beats = 0;

   always #5 clk = ~clk;

   conv2d_3x3 #(
      .IN_HEIGHT(4), .IN_WIDTH(4), .IN_CHANNEL(2), .WORDS(1),
      .WORD_WIDTH(8), .FILTERS(8), .KERNEL_BUF_WIDTH(32)
   ) dut (
      .i_aclk(clk), .i_aresetn(rst_n),
      .i_tvalid(i_tvalid), .o_tready(o_tready), .i_tdata(i_tdata),
      .i_kernel_tvalid(i_kernel_tvalid), .o_kernel_tready(o_kernel_tready),
      .i_kernel_tdata(i_kernel_tdata),
      .i_tready(i_tready), .o_tvalid(o_tvalid), .o_tdata(o_tdata)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic timeout(input string name);
      n_tests++;
      n_fail++;
      $display("FAIL %s: timed out, got no event expected one", name);
   endtask

   always @(negedge clk) begin
      if (rst_n === 1'b1 && o_tvalid === 1'b1) begin
         if (sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL extra_beat: got %h expected no beat", o_tdata);
         end else if (i_tready === 1'b1) begin
            mon_exp = sb.pop_front();
            check("out_beat", o_tdata, mon_exp);
            n_beats++;
         end else begin
            check("stall_hold", o_tdata, sb[0]);
         end
      end
   end

   function automatic logic [31:0] kbeat(input int mode, input int b);
      case (mode)
         0:       return 32'h01010101;
         1:       return (b % 2 == 0) ? 32'h00FFFEFD : 32'h04030201;
         2:       return (b == 18 || b == 19) ? 32'h01010101 : 32'h0;
         default: return (b == 8 || b == 9) ? 32'h01010101 : 32'h0;
      endcase
   endfunction

   function automatic logic [7:0] img_word(input int mode, input int i);
      case (mode)
         0:       return 8'h01;
         1:       return 8'(i);
         default: return 8'h10;
      endcase
   endfunction

   task automatic do_reset();
      i_tvalid = 1'b0; i_tdata = '0; i_kernel_tvalid = 1'b0; i_kernel_tdata = '0; i_tready = 1'b1;
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic load_kernel(input int mode);
      for (int b = 0; b < 36; b++) begin
         i_kernel_tdata = kbeat(mode, b);
         i_kernel_tvalid = 1'b1;
         @(negedge clk);
         check("kernel_tready_hi", 32'(o_kernel_tready), 32'd1);
         @(posedge clk); #1;
      end
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check("kernel_tready_lo", 32'(o_kernel_tready), 32'd0);
         @(posedge clk); #1;
      end
      i_kernel_tvalid = 1'b0;
   endtask

   task automatic send_image(input int mode, input int count);
      for (int i = 0; i < count; i++) begin
         int guard = 0;
         bit done = 0;
         i_tdata  = img_word(mode, i);
         i_tvalid = 1'b1;
         while (!done) begin
            @(negedge clk);
            if (o_tready === 1'b1) done = 1;
            else if (++guard > 5000) begin timeout("pixel_accept"); done = 1; end
         end
         @(posedge clk); #1;
      end
      i_tvalid = 1'b0;
   endtask

   task automatic wait_drain(input string name);
      int guard = 0;
      bit done = 0;
      while (!done) begin
         @(negedge clk);
         if (sb.size() == 0 && o_tready === 1'b1) done = 1;
         else if (++guard > 5000) begin timeout(name); done = 1; end
      end
      repeat (4) @(posedge clk);
      #1;
      check({name, "_tready"}, 32'(o_tready), 32'd1);
   endtask

   task automatic push_pair(input logic [31:0] a, input logic [31:0] b);
      sb.push_back(a);
      sb.push_back(b);
   endtask

   initial begin
      int base;
      rst_n = 1'b0; i_tvalid = 1'b0; i_tdata = '0; i_kernel_tvalid = 1'b0;
      i_kernel_tdata = '0; i_tready = 1'b1;
      #2;
      check("rst_async_tvalid", 32'(o_tvalid), 32'd0);
      do_reset();
      check("rst_tready", 32'(o_tready), 32'd1);
      check("rst_ktready", 32'(o_kernel_tready), 32'd1);
      check("rst_tvalid", 32'(o_tvalid), 32'd0);
      check("rst_tdata", o_tdata, 32'd0);

      // image before kernel: must wait, and input while not ready is ignored
      base = n_beats;
      repeat (8) sb.push_back(32'h12121212);
      send_image(0, 32);
      i_tvalid = 1'b1; i_tdata = 8'h55;
      repeat (20) @(posedge clk);
      #1;
      i_tvalid = 1'b0;
      check("wait_tready", 32'(o_tready), 32'd0);
      check("wait_tvalid", 32'(o_tvalid), 32'd0);
      load_kernel(0);
      wait_drain("ones");
      check("ones_beats", 32'(n_beats - base), 32'd8);

      base = n_beats;
      repeat (8) sb.push_back(32'h7F7F7F7F);
      send_image(1, 32);
      wait_drain("ramp_sat");
      check("ramp_sat_beats", 32'(n_beats - base), 32'd8);

      // two images back to back with a downstream stall
      base = n_beats;
      repeat (8) sb.push_back(32'h12121212);
      repeat (8) sb.push_back(32'h7F7F7F7F);
      fork
         begin
            send_image(0, 32);
            send_image(1, 32);
         end
         begin
            int guard = 0;
            while (n_beats < base + 1 && guard < 5000) begin @(negedge clk); guard++; end
            @(posedge clk); #1;
            i_tready = 1'b0;
            guard = 0;
            do begin @(negedge clk); guard++; end while (o_tvalid !== 1'b1 && guard < 5000);
            if (guard >= 5000) timeout("stall_valid");
            repeat (5) @(posedge clk);
            #1;
            i_tready = 1'b1;
         end
      join
      wait_drain("b2b");
      check("b2b_beats", 32'(n_beats - base), 32'd16);

      // reset mid-image clears everything, including the kernel
      send_image(1, 10);
      @(posedge clk); #1;
      rst_n = 1'b0;
      #2;
      check("mid_rst_tready", 32'(o_tready), 32'd1);
      check("mid_rst_ktready", 32'(o_kernel_tready), 32'd1);
      check("mid_rst_tvalid", 32'(o_tvalid), 32'd0);
      check("mid_rst_tdata", o_tdata, 32'd0);
      do_reset();
      base = n_beats;
      repeat (4) push_pair(32'h00EEDCCA, 32'h48362412);
      send_image(0, 32);
      repeat (50) @(posedge clk);
      #1;
      check("nokernel_tvalid", 32'(o_tvalid), 32'd0);
      check("nokernel_ktready", 32'(o_kernel_tready), 32'd1);
      load_kernel(1);
      wait_drain("signed");
      repeat (4) push_pair(32'h00808080, 32'h7F7F7F7F);
      send_image(2, 32);
      wait_drain("neg_sat");
      check("signed_beats", 32'(n_beats - base), 32'd16);

      // single-tap kernels check window and channel addressing
      do_reset();
      push_pair(32'h0B0B0B0B, 32'h0B0B0B0B);
      push_pair(32'h0D0D0D0D, 32'h0D0D0D0D);
      push_pair(32'h13131313, 32'h13131313);
      push_pair(32'h15151515, 32'h15151515);
      load_kernel(2);
      send_image(1, 32);
      wait_drain("tap_center_c1");

      do_reset();
      push_pair(32'h04040404, 32'h04040404);
      push_pair(32'h06060606, 32'h06060606);
      push_pair(32'h0C0C0C0C, 32'h0C0C0C0C);
      push_pair(32'h0E0E0E0E, 32'h0E0E0E0E);
      load_kernel(3);
      send_image(1, 32);
      wait_drain("tap_top_right_c0");

      check("sb_empty", 32'(sb.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
